s_pipe_fetch_arb: RTL and testbench

S_PIPE_FETCH_ARB -- requirements
Module: s_pipe_fetch_arb

---
 rtl/s_pipe_fetch_arb_if.sv | 46 ++++
 rtl/s_pipe_fetch_arb.sv | 145 ++++++++++++++
 tb/tb_s_pipe_fetch_arb.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_pipe_fetch_arb_if.sv
`default_nettype none
// ============================================================================
// s_pipe_fetch_arb_if : shared-imem fetch bus between the speculative pipes,
//                       the fetch arbiter and the instruction memory port.
// Rev 1.0 - initial release
// ============================================================================

package sys;
    typedef logic [31:0] addr_t;
endpackage

interface s_pipe_fetch_arb_if #(
    parameter int s_pipe_cnt = 3
);
    localparam int HID_W = (s_pipe_cnt > 1) ? $clog2(s_pipe_cnt) : 1;

    logic                  en;
    logic [s_pipe_cnt-1:0] fetch_req;
    sys::addr_t            fetch_addr [s_pipe_cnt];
    logic [s_pipe_cnt-1:0] s_pipe_rst;
    logic [HID_W-1:0]      head_s_pipe_id;
    logic                  imem_req_rdy;
    logic                  imem_rsp_valid;
    logic [31:0]           imem_rsp_data;
    logic                  imem_req_valid;
    sys::addr_t            imem_req_addr;
    logic [s_pipe_cnt-1:0] fetch_gnt;
    logic [s_pipe_cnt-1:0] fetch_rsp_valid;
    logic [31:0]           fetch_rsp_inst;

    modport master (
        output en, fetch_req, fetch_addr, s_pipe_rst, head_s_pipe_id,
               imem_req_rdy, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_req_addr, fetch_gnt, fetch_rsp_valid,
               fetch_rsp_inst
    );

    modport slave (
        input  en, fetch_req, fetch_addr, s_pipe_rst, head_s_pipe_id,
               imem_req_rdy, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_req_addr, fetch_gnt, fetch_rsp_valid,
               fetch_rsp_inst
    );
endinterface

`default_nettype wire

// File: rtl/s_pipe_fetch_arb.sv
`default_nettype none
// ============================================================================
// s_pipe_fetch_arb : round-robin arbiter giving N speculative pipes one shared
//                    instruction-memory port, one transaction outstanding.
//                    Optional macro FETCH_ARB_HEAD_PRIO_EN: head pipe wins.
// Rev 1.0 - initial release
// ============================================================================

module s_pipe_fetch_arb #(
    parameter int s_pipe_cnt = 3
) (
    input  wire                clk,
    input  wire                rst,
    s_pipe_fetch_arb_if.slave  bus
);

    localparam int PTR_W = (s_pipe_cnt > 1) ? $clog2(s_pipe_cnt) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic             kill_q, kill_d;
    sys::addr_t       addr_q, addr_d;

    logic [s_pipe_cnt-1:0] w_elig;
    logic                  w_found;
    logic [PTR_W-1:0]      w_win;
    logic [PTR_W-1:0]      w_idx;
    int                    w_sum;
    logic                  w_owner_flush;

    // Round-robin search starting at rr_q; a pipe being flushed is not eligible.
    always_comb begin
        w_elig  = bus.fetch_req & ~bus.s_pipe_rst;
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        w_sum   = 0;
        for (int i = 0; i < s_pipe_cnt; i++) begin
            w_sum = int'(rr_q) + i;
            if (w_sum >= s_pipe_cnt) begin
                w_sum = w_sum - s_pipe_cnt;
            end
            w_idx = PTR_W'(w_sum);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
`ifdef FETCH_ARB_HEAD_PRIO_EN
        if ((int'(bus.head_s_pipe_id) < s_pipe_cnt) && w_elig[bus.head_s_pipe_id]) begin
            w_found = 1'b1;
            w_win   = bus.head_s_pipe_id;
        end
`endif
    end

`ifndef FETCH_ARB_HEAD_PRIO_EN
    logic w_unused_head;
    assign w_unused_head = ^bus.head_s_pipe_id;
`endif

    always_comb begin
        state_d              = state_q;
        rr_d                 = rr_q;
        owner_d              = owner_q;
        kill_d               = kill_q;
        addr_d               = addr_q;
        bus.imem_req_valid   = 1'b0;
        bus.imem_req_addr    = addr_q;
        bus.fetch_gnt        = '0;
        bus.fetch_rsp_valid  = '0;
        bus.fetch_rsp_inst   = '0;
        w_owner_flush        = bus.s_pipe_rst[owner_q];

        case (state_q)
            ST_IDLE: begin
                if (bus.en && w_found) begin
                    bus.fetch_gnt[w_win] = 1'b1;
                    addr_d  = bus.fetch_addr[w_win];
                    owner_d = w_win;
                    kill_d  = 1'b0;
                    rr_d    = (w_win == PTR_W'(s_pipe_cnt - 1)) ? '0 : w_win + 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                bus.imem_req_valid = 1'b1;
                if (w_owner_flush) begin
                    kill_d = 1'b1;
                end
                if (bus.imem_req_rdy) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_owner_flush) begin
                    kill_d = 1'b1;
                end
                // A flushed owner still drains the memory response, it is just not delivered.
                if (bus.imem_rsp_valid) begin
                    if (!kill_q && !w_owner_flush) begin
                        bus.fetch_rsp_valid[owner_q] = 1'b1;
                        bus.fetch_rsp_inst           = bus.imem_rsp_data;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rst) begin
            bus.imem_req_valid  = 1'b0;
            bus.imem_req_addr   = '0;
            bus.fetch_gnt       = '0;
            bus.fetch_rsp_valid = '0;
            bus.fetch_rsp_inst  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            kill_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            kill_q  <= kill_d;
            addr_q  <= addr_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_s_pipe_fetch_arb.sv
`default_nettype none
// ============================================================================
// tb_s_pipe_fetch_arb : directed scenarios plus randomized traffic checked
//                       against a transaction-level arbiter model.
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_s_pipe_fetch_arb;

    localparam int N = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    s_pipe_fetch_arb_if #(.s_pipe_cnt(N)) bus ();

    s_pipe_fetch_arb #(.s_pipe_cnt(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = free, 1 = request presented, 2 = awaiting response.
    int          m_phase, m_rr, m_owner, m_kill, m_win;
    logic [31:0] m_addr;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [31:0]  exp_inst, exp_addr;
    logic         exp_rqv;

    task automatic predict();
        exp_gnt  = '0;
        exp_rv   = '0;
        exp_inst = '0;
        exp_rqv  = 1'b0;
        exp_addr = m_addr;
        m_win    = -1;
        if (rst) begin
            exp_addr = '0;
            return;
        end
        case (m_phase)
            0: if (bus.en) begin
`ifdef FETCH_ARB_HEAD_PRIO_EN
                if (int'(bus.head_s_pipe_id) < N && bus.fetch_req[bus.head_s_pipe_id]
                    && !bus.s_pipe_rst[bus.head_s_pipe_id])
                    m_win = int'(bus.head_s_pipe_id);
`endif
                for (int k = 0; k < N && m_win < 0; k++) begin
                    int p;
                    p = (m_rr + k) % N;
                    if (bus.fetch_req[p] && !bus.s_pipe_rst[p]) m_win = p;
                end
                if (m_win >= 0) exp_gnt[m_win] = 1'b1;
            end
            1: exp_rqv = 1'b1;
            2: if (bus.imem_rsp_valid && m_kill == 0 && !bus.s_pipe_rst[m_owner]) begin
                exp_rv[m_owner] = 1'b1;
                exp_inst = bus.imem_rsp_data;
            end
            default: ;
        endcase
    endtask

    task automatic advance();
        predict();
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_rr = 0; m_owner = 0; m_kill = 0; m_addr = '0;
        end else begin
            case (m_phase)
                0: if (m_win >= 0) begin
                    m_addr  = bus.fetch_addr[m_win];
                    m_owner = m_win;
                    m_kill  = 0;
                    m_rr    = (m_win + 1) % N;
                    m_phase = 1;
                end
                1: begin
                    if (bus.s_pipe_rst[m_owner]) m_kill = 1;
                    if (bus.imem_req_rdy) m_phase = 2;
                end
                2: begin
                    if (bus.s_pipe_rst[m_owner]) m_kill = 1;
                    if (bus.imem_rsp_valid) m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        bus.en = 1'b1;
        bus.fetch_req = '0;
        bus.s_pipe_rst = '0;
        bus.head_s_pipe_id = '0;
        bus.imem_req_rdy = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        for (int i = 0; i < N; i++) bus.fetch_addr[i] = 32'h100 * (i + 1);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        bus.fetch_req = '1;
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++;
        if (bus.fetch_gnt !== '0 || bus.fetch_rsp_valid !== '0) begin
            errors++; $display("FAIL reset_pulses gnt=%b rsp_valid=%b required 000/000", bus.fetch_gnt, bus.fetch_rsp_valid);
        end
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0 || bus.fetch_rsp_inst !== 32'h0) begin
            errors++; $display("FAIL reset_bus req_valid=%b addr=%h inst=%h required 0/0/0", bus.imem_req_valid, bus.imem_req_addr, bus.fetch_rsp_inst);
        end
        advance();
        advance();
        rst = 1'b0;
        bus.fetch_req = '0;
        bus.imem_rsp_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0 || bus.fetch_gnt !== '0 || bus.imem_req_addr !== 32'h0) begin
            errors++; $display("FAIL post_reset_idle req_valid=%b gnt=%b addr=%h required 0/000/0", bus.imem_req_valid, bus.fetch_gnt, bus.imem_req_addr);
        end
    endtask

    task automatic test_round_robin();
        clear_inputs();
        bus.fetch_req = '1;
        for (int t = 0; t < 4; t++) begin
            int p;
            logic [N-1:0] oh;
            logic [31:0] data;
            p = t % N;
            oh = N'(1 << p);
            #1;
            checks++;
            if (bus.fetch_gnt !== oh) begin
                errors++; $display("FAIL rr_grant[%0d] gnt=%b required %b", t, bus.fetch_gnt, oh);
            end
            advance();
            #1;
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100 * (p + 1)) begin
                errors++; $display("FAIL rr_addr[%0d] valid=%b addr=%h required 1/%h", t, bus.imem_req_valid, bus.imem_req_addr, 32'h100 * (p + 1));
            end
            advance();
            data = $urandom;
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data = data;
            #1;
            checks++;
            if (bus.fetch_rsp_valid !== oh || bus.fetch_rsp_inst !== data) begin
                errors++; $display("FAIL rr_rsp[%0d] rsp_valid=%b inst=%h required %b/%h", t, bus.fetch_rsp_valid, bus.fetch_rsp_inst, oh, data);
            end
            advance();
            bus.imem_rsp_valid = 1'b0;
        end
    endtask

    task automatic test_kill();
        clear_inputs();
        bus.fetch_req = 3'b010;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b010) begin
            errors++; $display("FAIL kill_grant gnt=%b required 010", bus.fetch_gnt);
        end
        advance();
        advance();
        bus.s_pipe_rst = 3'b010;
        advance();
        bus.s_pipe_rst = '0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'h0000_0013;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== '0) begin
            errors++; $display("FAIL kill_flag rsp_valid=%b required 000", bus.fetch_rsp_valid);
        end
        advance();
        bus.imem_rsp_valid = 1'b0;
        bus.fetch_req = '1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b100) begin
            errors++; $display("FAIL kill_next_grant gnt=%b required 100", bus.fetch_gnt);
        end
        advance();
        advance();
        bus.imem_rsp_valid = 1'b1;
        bus.s_pipe_rst = 3'b100;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== '0) begin
            errors++; $display("FAIL kill_same_cycle rsp_valid=%b required 000", bus.fetch_rsp_valid);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_stall();
        int extra;
        clear_inputs();
        bus.fetch_req = '1;
        bus.imem_req_rdy = 1'b0;
        extra = 0;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b001) begin
            errors++; $display("FAIL stall_grant gnt=%b required 001", bus.fetch_gnt);
        end
        advance();
        for (int c = 0; c < 5; c++) begin
            bus.imem_req_rdy = (c == 4);
            #1;
            checks++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
                errors++; $display("FAIL stall_hold[%0d] valid=%b addr=%h required 1/00000100", c, bus.imem_req_valid, bus.imem_req_addr);
            end
            if (bus.fetch_gnt !== '0) extra++;
            advance();
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL stall_single_grant extra_grants=%0d required 0", extra);
        end
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== 3'b001) begin
            errors++; $display("FAIL stall_rsp rsp_valid=%b required 001", bus.fetch_rsp_valid);
        end
        advance();
        clear_inputs();
    endtask

    task automatic test_en_gate();
        int seen;
        clear_inputs();
        bus.fetch_req = '1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b010) begin
            errors++; $display("FAIL en_grant gnt=%b required 010", bus.fetch_gnt);
        end
        advance();
        bus.en = 1'b0;
        advance();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data = 32'hCAFE_0001;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== 3'b010 || bus.fetch_rsp_inst !== 32'hCAFE_0001) begin
            errors++; $display("FAIL en_inflight rsp_valid=%b inst=%h required 010/cafe0001", bus.fetch_rsp_valid, bus.fetch_rsp_inst);
        end
        advance();
        bus.imem_rsp_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (bus.fetch_gnt !== '0) seen++;
            advance();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL en_no_grant grant_cycles=%0d required 0", seen);
        end
        bus.en = 1'b1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b100) begin
            errors++; $display("FAIL en_resume gnt=%b required 100", bus.fetch_gnt);
        end
        advance();
        advance();
        bus.imem_rsp_valid = 1'b1;
        advance();
        clear_inputs();
    endtask

    task automatic test_rst_wait();
        clear_inputs();
        bus.fetch_req = '1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b001) begin
            errors++; $display("FAIL rstw_grant gnt=%b required 001", bus.fetch_gnt);
        end
        advance();
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        bus.fetch_req = '0;
        bus.imem_rsp_valid = 1'b1;
        #1;
        checks++;
        if (bus.fetch_rsp_valid !== '0 || bus.imem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rstw_drop rsp_valid=%b req_valid=%b required 000/0", bus.fetch_rsp_valid, bus.imem_req_valid);
        end
        advance();
        bus.imem_rsp_valid = 1'b0;
        bus.fetch_req = '1;
        #1;
        checks++;
        if (bus.fetch_gnt !== 3'b001) begin
            errors++; $display("FAIL rstw_idle gnt=%b required 001", bus.fetch_gnt);
        end
        advance();
        advance();
        bus.imem_rsp_valid = 1'b1;
        advance();
        clear_inputs();
    endtask

    task automatic test_head_prio();
        logic [N-1:0] req1, req2;
`ifdef FETCH_ARB_HEAD_PRIO_EN
        req1 = 3'b100;
        req2 = 3'b001;
`else
        req1 = 3'b001;
        req2 = 3'b010;
`endif
        clear_inputs();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        bus.head_s_pipe_id = 2'd2;
        bus.fetch_req = '1;
        #1;
        checks++;
        if (bus.fetch_gnt !== req1) begin
            errors++; $display("FAIL head_grant gnt=%b required %b", bus.fetch_gnt, req1);
        end
        advance();
        advance();
        bus.imem_rsp_valid = 1'b1;
        advance();
        bus.imem_rsp_valid = 1'b0;
        bus.fetch_req = 3'b011;
        #1;
        checks++;
        if (bus.fetch_gnt !== req2) begin
            errors++; $display("FAIL head_rr_ptr gnt=%b required %b", bus.fetch_gnt, req2);
        end
        advance();
        advance();
        bus.imem_rsp_valid = 1'b1;
        advance();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 49) == 0);
            bus.en = ($urandom_range(0, 3) != 0);
            bus.fetch_req = N'($urandom);
            bus.s_pipe_rst = ($urandom_range(0, 5) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            bus.head_s_pipe_id = 2'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) bus.fetch_addr[i] = $urandom;
            bus.imem_req_rdy = $urandom_range(0, 1) == 1;
            bus.imem_rsp_valid = $urandom_range(0, 2) == 0;
            bus.imem_rsp_data = $urandom;
            #1;
            predict();
            checks++;
            if (bus.fetch_gnt !== exp_gnt || bus.imem_req_valid !== exp_rqv) begin
                errors++; $display("FAIL rand_req[%0d] gnt=%b valid=%b required %b/%b", c, bus.fetch_gnt, bus.imem_req_valid, exp_gnt, exp_rqv);
            end
            if (exp_rqv) begin
                checks++;
                if (bus.imem_req_addr !== exp_addr) begin
                    errors++; $display("FAIL rand_addr[%0d] addr=%h required %h", c, bus.imem_req_addr, exp_addr);
                end
            end
            checks++;
            if (bus.fetch_rsp_valid !== exp_rv || (exp_rv != '0 && bus.fetch_rsp_inst !== exp_inst)) begin
                errors++; $display("FAIL rand_rsp[%0d] rsp_valid=%b inst=%h required %b/%h", c, bus.fetch_rsp_valid, bus.fetch_rsp_inst, exp_rv, exp_inst);
            end
            advance();
        end
        clear_inputs();
    endtask

    initial begin
        m_phase = 0; m_rr = 0; m_owner = 0; m_kill = 0; m_win = -1; m_addr = '0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_kill();
        test_stall();
        test_en_gate();
        test_rst_wait();
        test_head_prio();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete required finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
